// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU, the result buffer and the writeback consumer.
// The buffer uses the slave modport; the driving environment uses master.
interface alu_result_buffer_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [DATA_W-1:0] in_y;
    logic              in_carry;
    logic              in_neg;
    logic              in_ovf;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_y;
    logic [3:0]        out_op;
    logic [3:0]        out_flags;

    modport master (
        output in_valid, in_op, in_y, in_carry, in_neg, in_ovf, out_ready,
        input  in_ready, out_valid, out_y, out_op, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_y, in_carry, in_neg, in_ovf, out_ready,
        output in_ready, out_valid, out_y, out_op, out_flags
    );
endinterface

// File: rtl/alu_result_buffer.sv
// FIFO stage behind the ALU: stores result, opcode and qualified flags per entry,
// and accumulates sticky status flags for software.
module alu_result_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_result_buffer_if.slave       bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [3:0]               sticky_flags,
    input  logic                     sticky_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] y_mem    [DEPTH];
    logic [3:0]        op_mem   [DEPTH];
    logic [3:0]        flag_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [3:0]    in_flags;
    logic          ready_int;
    logic          valid_int;

    assign ready_int = (count != CW'(DEPTH));
    assign valid_int = (count != '0);
    assign push      = bus.in_valid & ready_int;
    assign pop       = valid_int & bus.out_ready;

    // ALU keeps carry/overflow latched across unrelated ops, so mask by opcode.
    always_comb begin
        in_flags    = '0;
        in_flags[0] = (bus.in_y == '0);
        in_flags[1] = bus.in_neg;
        in_flags[2] = ((bus.in_op == 4'd6) || (bus.in_op == 4'd7)) ? bus.in_carry : 1'b0;
        in_flags[3] = (bus.in_op == 4'd7) ? bus.in_ovf : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            y_mem[wr_ptr]    <= bus.in_y;
            op_mem[wr_ptr]   <= bus.in_op;
            flag_mem[wr_ptr] <= in_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sticky_flags <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (sticky_clr)
                sticky_flags <= push ? in_flags : '0;
            else if (push)
                sticky_flags <= sticky_flags | in_flags;
        end
    end

    assign bus.in_ready  = ready_int;
    assign bus.out_valid = valid_int;
    assign bus.out_y     = valid_int ? y_mem[rd_ptr]    : '0;
    assign bus.out_op    = valid_int ? op_mem[rd_ptr]   : '0;
    assign bus.out_flags = valid_int ? flag_mem[rd_ptr] : '0;
endmodule
